// File: rtl/burst_line_adaptor_pkg.sv
// Shared types for the line-to-burst adaptor.
package burst_line_adaptor_pkg;
    typedef enum logic [1:0] {IDLE, WRITE, READ, RESP} state_t;
endpackage

// File: rtl/burst_line_adaptor_line_beat_counter.sv
// Beat counter with load/enable and a rotated slot index (start+cnt) mod BEATS.
module line_beat_counter #(
    parameter int BEATS = 4,
    parameter int CNT_W = $clog2(BEATS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             en,
    input  logic [CNT_W-1:0] start,
    output logic [CNT_W-1:0] cnt,
    output logic [CNT_W-1:0] idx,
    output logic             at_last
);
    logic [CNT_W:0] sum;

    assign at_last = (cnt == CNT_W'(BEATS - 1));

    // One conditional subtract is enough: both operands are below BEATS.
    always_comb begin
        sum = {1'b0, start} + {1'b0, cnt};
        if (sum >= (CNT_W+1)'(BEATS))
            sum = sum - (CNT_W+1)'(BEATS);
    end

    assign idx = sum[CNT_W-1:0];

    always_ff @(posedge clk) begin
        if (rst)
            cnt <= '0;
        else if (load)
            cnt <= load_val;
        else if (en)
            cnt <= at_last ? '0 : cnt + 1'b1;
    end
endmodule

// File: rtl/burst_line_adaptor.sv
// Line-to-burst adaptor: splits write lines into beats, assembles read beats into a line.
// Define BURST_LINE_ADAPTOR_CWF_EN for critical-word-first read ordering.
module burst_line_adaptor
    import burst_line_adaptor_pkg::*;
#(
    parameter int LINE_W  = 256,
    parameter int BURST_W = 64,
    parameter int ADDR_W  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              abort,
    input  logic [ADDR_W-1:0] cla_addr,
    input  logic              cla_read,
    input  logic              cla_write,
    input  logic [LINE_W-1:0] cla_wdata,
    output logic [LINE_W-1:0] cla_rdata,
    output logic              cla_resp,
    output logic [ADDR_W-1:0] cla_raddr,
    input  logic              bmem_ready,
    input  logic [ADDR_W-1:0] bmem_raddr,
    input  logic [BURST_W-1:0] bmem_rdata,
    input  logic              bmem_rvalid,
    output logic [ADDR_W-1:0] bmem_addr,
    output logic              bmem_read,
    output logic              bmem_write,
    output logic [BURST_W-1:0] bmem_wdata
);
    localparam int BEATS    = LINE_W / BURST_W;
    localparam int CNT_W    = $clog2(BEATS);
    localparam int LINE_OFF = $clog2(LINE_W / 8);
    localparam logic [ADDR_W-1:0] LINE_MASK = ~((ADDR_W'(1) << LINE_OFF) - ADDR_W'(1));

    state_t                          state;
    logic                            drop;
    logic [CNT_W-1:0]                start_q, req_start, cnt, idx;
    logic                            at_last, accept, cnt_en;
    logic [ADDR_W-1:0]               line_addr, rd_addr;
    logic [BEATS-1:0][BURST_W-1:0]   line_q, wbeats;

    assign line_addr = cla_addr & LINE_MASK;
    assign wbeats    = cla_wdata;
    assign cla_rdata = line_q;

`ifdef BURST_LINE_ADAPTOR_CWF_EN
    localparam int BEAT_OFF = $clog2(BURST_W / 8);
    localparam logic [ADDR_W-1:0] BEAT_MASK = ~((ADDR_W'(1) << BEAT_OFF) - ADDR_W'(1));
    // Memory returns the addressed beat first; it lands in its natural slot.
    assign rd_addr   = cla_addr & BEAT_MASK;
    assign req_start = CNT_W'(cla_addr[LINE_OFF-1:BEAT_OFF]);
`else
    assign rd_addr   = line_addr;
    assign req_start = '0;
`endif

    assign accept = (state == IDLE) && (cla_read || cla_write) && bmem_ready && !abort;
    assign cnt_en = ((state == WRITE) && bmem_ready) || ((state == READ) && bmem_rvalid);

    line_beat_counter #(.BEATS(BEATS), .CNT_W(CNT_W)) u_cnt (
        .clk      (clk),
        .rst      (rst),
        .load     (accept),
        .load_val (cla_read ? '0 : CNT_W'(1)),
        .en       (cnt_en),
        .start    (start_q),
        .cnt      (cnt),
        .idx      (idx),
        .at_last  (at_last)
    );

    // Command side is combinational so the first beat goes out in the accept cycle.
    always_comb begin
        bmem_read  = 1'b0;
        bmem_write = 1'b0;
        bmem_addr  = '0;
        bmem_wdata = '0;
        case (state)
            IDLE: if (accept) begin
                if (cla_read) begin
                    bmem_read = 1'b1;
                    bmem_addr = rd_addr;
                end else begin
                    bmem_write = 1'b1;
                    bmem_addr  = line_addr;
                    bmem_wdata = wbeats[0];
                end
            end
            WRITE: begin
                bmem_write = 1'b1;
                bmem_addr  = line_addr;
                bmem_wdata = wbeats[cnt];
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            drop      <= 1'b0;
            cla_resp  <= 1'b0;
            cla_raddr <= '0;
            line_q    <= '0;
            start_q   <= '0;
        end else begin
            cla_resp <= 1'b0;
            case (state)
                IDLE: if (accept) begin
                    start_q <= cla_read ? req_start : '0;
                    if (cla_read) begin
                        state <= READ;
                    end else begin
                        state     <= WRITE;
                        cla_raddr <= '0;
                    end
                end
                WRITE: if (bmem_ready && at_last) begin
                    state    <= RESP;
                    cla_resp <= 1'b1;
                end
                READ: begin
                    if (abort)
                        drop <= 1'b1;
                    if (bmem_rvalid) begin
                        line_q[idx] <= bmem_rdata;
                        if (cnt == '0)
                            cla_raddr <= bmem_raddr;
                        if (at_last) begin
                            state    <= RESP;
                            cla_resp <= !(drop || abort);
                        end
                    end
                end
                RESP: begin
                    state <= IDLE;
                    drop  <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_burst_line_adaptor.sv
// Randomized transaction-level bench for burst_line_adaptor against a line/beat reference model.
module tb_burst_line_adaptor;
    localparam int LINE_W  = 256;
    localparam int BURST_W = 64;
    localparam int ADDR_W  = 32;
    localparam int BEATS   = LINE_W / BURST_W;

    typedef logic [LINE_W-1:0] val_t;

    logic               clk = 1'b0;
    logic               rst, abort, cla_read, cla_write, cla_resp;
    logic [ADDR_W-1:0]  cla_addr, cla_raddr, bmem_raddr, bmem_addr;
    logic [LINE_W-1:0]  cla_wdata, cla_rdata;
    logic               bmem_ready, bmem_rvalid, bmem_read, bmem_write;
    logic [BURST_W-1:0] bmem_rdata, bmem_wdata;

    int   n_cmp = 0, n_err = 0;
    val_t exp_line = '0;
    logic [ADDR_W-1:0] exp_raddr = '0;

    always #5 clk = ~clk;

    burst_line_adaptor #(.LINE_W(LINE_W), .BURST_W(BURST_W), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst(rst), .abort(abort),
        .cla_addr(cla_addr), .cla_read(cla_read), .cla_write(cla_write), .cla_wdata(cla_wdata),
        .cla_rdata(cla_rdata), .cla_resp(cla_resp), .cla_raddr(cla_raddr),
        .bmem_ready(bmem_ready), .bmem_raddr(bmem_raddr), .bmem_rdata(bmem_rdata),
        .bmem_rvalid(bmem_rvalid), .bmem_addr(bmem_addr), .bmem_read(bmem_read),
        .bmem_write(bmem_write), .bmem_wdata(bmem_wdata)
    );

    task automatic chk(input string tag, input val_t got, input val_t exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic val_t rand_line();
        val_t r;
        for (int j = 0; j < LINE_W / 32; j++) r[j*32 +: 32] = $urandom;
        return r;
    endfunction

    // Entered and left on a negedge, state IDLE.
    task automatic do_write(input logic [ADDR_W-1:0] a, input val_t d, input int stall_pct,
                            input int hold_beat, input int hold_cyc);
        int k = 0, cyc = 0, held = 0;
        bit rdy, exp_wr;
        cla_write = 1'b1; cla_read = 1'b0; cla_addr = a; cla_wdata = d;
        while (k < BEATS && cyc < 200) begin
            if (k == hold_beat && held < hold_cyc) begin rdy = 1'b0; held++; end
            else rdy = ($urandom_range(99) >= stall_pct);
            bmem_ready  = rdy;
            abort       = (k > 0) ? 1'($urandom_range(1)) : 1'b0;
            bmem_rvalid = 1'($urandom_range(1));
            bmem_rdata  = {$urandom, $urandom};
            exp_wr = (k > 0) || rdy;
            #1;
            if (k == 0) chk("rdata_hold", cla_rdata, exp_line);
            chk("wr_strobe", val_t'(bmem_write), val_t'(exp_wr));
            chk("wr_noread", val_t'(bmem_read), '0);
            chk("wr_noresp", val_t'(cla_resp), '0);
            if (exp_wr) begin
                chk("wr_addr", val_t'(bmem_addr), val_t'(a & ~ADDR_W'(LINE_W/8 - 1)));
                chk("wr_beat", val_t'(bmem_wdata), val_t'(d[k*BURST_W +: BURST_W]));
                if (rdy) k++;
            end
            @(negedge clk); cyc++;
        end
        if (cyc >= 200) chk("wr_timeout", '0, val_t'(1));
        exp_raddr = '0;
        abort = 1'b0; bmem_ready = 1'b1; bmem_rvalid = 1'b0;
        #1;
        chk("wr_resp", val_t'(cla_resp), val_t'(1));
        chk("wr_resp_noissue", val_t'(bmem_read | bmem_write), '0);
        chk("wr_raddr", val_t'(cla_raddr), val_t'(exp_raddr));
        chk("wr_rdata_kept", cla_rdata, exp_line);
        @(negedge clk);
        cla_write = 1'b0;
    endtask

    task automatic do_read(input logic [ADDR_W-1:0] a, input val_t ln, input int gap_pct,
                           input int abort_at, input bit both);
        int i = 0, cyc = 0, start;
        bit acc = 1'b0, aborted = 1'b0, rdy;
        logic [ADDR_W-1:0] tag, exp_a;
        tag = $urandom;
`ifdef BURST_LINE_ADAPTOR_CWF_EN
        start = int'(a % (LINE_W/8)) / (BURST_W/8);
        exp_a = a & ~ADDR_W'(BURST_W/8 - 1);
`else
        start = 0;
        exp_a = a & ~ADDR_W'(LINE_W/8 - 1);
`endif
        cla_read = 1'b1; cla_write = both; cla_addr = a; cla_wdata = rand_line();
        while (!acc && cyc < 50) begin
            rdy = ($urandom_range(3) != 0);
            bmem_ready  = rdy;
            bmem_rvalid = 1'($urandom_range(1));
            bmem_rdata  = {$urandom, $urandom};
            bmem_raddr  = $urandom;
            #1;
            chk("rdata_hold", cla_rdata, exp_line);
            chk("no_resp", val_t'(cla_resp), '0);
            chk("rd_cmd", val_t'(bmem_read), val_t'(rdy));
            chk("rd_nowr", val_t'(bmem_write), '0);
            if (rdy) chk("rd_addr", val_t'(bmem_addr), val_t'(exp_a));
            acc = rdy;
            @(negedge clk); cyc++;
        end
        while (acc && i < BEATS && cyc < 300) begin
            bmem_ready = 1'($urandom_range(1));
            if (abort_at == i && !aborted) begin
                abort = 1'b1; bmem_rvalid = 1'b0; aborted = 1'b1;
            end else begin
                abort = 1'b0; bmem_rvalid = ($urandom_range(99) >= gap_pct);
            end
            bmem_rdata = ln[i*BURST_W +: BURST_W];
            bmem_raddr = (i == 0) ? tag : $urandom;
            #1;
            chk("rd_bus_quiet", val_t'({bmem_read, bmem_write}), '0);
            chk("rd_noresp", val_t'(cla_resp), '0);
            if (bmem_rvalid) begin
                exp_line[((start + i) % BEATS)*BURST_W +: BURST_W] = bmem_rdata;
                if (i == 0) exp_raddr = tag;
                i++;
            end
            @(negedge clk); cyc++;
        end
        if (!acc || cyc >= 300) chk("rd_timeout", '0, val_t'(1));
        abort = 1'b0; bmem_ready = 1'b1;
        bmem_rvalid = 1'b1; bmem_rdata = {$urandom, $urandom};
        #1;
        chk("rd_resp", val_t'(cla_resp), val_t'(!aborted));
        chk("rd_data", cla_rdata, exp_line);
        chk("rd_raddr", val_t'(cla_raddr), val_t'(exp_raddr));
        chk("rd_resp_noissue", val_t'(bmem_read | bmem_write), '0);
        @(negedge clk);
        cla_read = 1'b0; cla_write = 1'b0; bmem_rvalid = 1'b0;
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_resp"},  val_t'(cla_resp), '0);
        chk({tag, "_rdata"}, cla_rdata, '0);
        chk({tag, "_raddr"}, val_t'(cla_raddr), '0);
        chk({tag, "_bus"},   val_t'({bmem_read, bmem_write, bmem_addr, bmem_wdata}), '0);
    endtask

    initial begin
        val_t ln;
        rst = 1'b1; abort = 1'b0; cla_read = 1'b0; cla_write = 1'b0;
        cla_addr = '0; cla_wdata = '0; bmem_ready = 1'b0; bmem_raddr = '0;
        bmem_rdata = '0; bmem_rvalid = 1'b0;
        repeat (3) @(negedge clk);
        #1 chk_idle_outputs("reset");
        @(negedge clk);
        rst = 1'b0;

        // Back-to-back beats 0x11.., 0x22.., 0x33.., 0x44..
        for (int i = 0; i < BEATS; i++)
            ln[i*BURST_W +: BURST_W] = 64'h1111_1111_1111_1111 * BURST_W'(i + 1);
        do_read(32'h8000_0040, ln, 0, -1, 1'b0);
        chk("rd_directed_line", cla_rdata, exp_line);

        do_write(32'h1234_5678, rand_line(), 0, 2, 2);
        do_read($urandom, rand_line(), 30, 2, 1'b0);
        do_read($urandom, rand_line(), 30, -1, 1'b1);

        // Abort while idle blocks issue.
        cla_read = 1'b1; abort = 1'b1; bmem_ready = 1'b1; cla_addr = $urandom;
        for (int c = 0; c < 3; c++) begin
            #1 chk("abort_idle", val_t'({bmem_read, bmem_write}), '0);
            @(negedge clk);
        end
        abort = 1'b0;
        do_read(32'hABCD_0010, rand_line(), 20, -1, 1'b0);

        for (int t = 0; t < 40; t++) begin
            if ($urandom_range(1) == 1)
                do_write($urandom, rand_line(), 30, -1, 0);
            else
                do_read($urandom, rand_line(), 30,
                        ($urandom_range(4) == 0) ? int'($urandom_range(BEATS - 1)) : -1,
                        1'($urandom_range(1)));
        end

        // Reset in the middle of a write burst.
        cla_write = 1'b1; cla_addr = $urandom; cla_wdata = rand_line(); bmem_ready = 1'b1;
        @(negedge clk);
        #1 chk("mid_wr_active", val_t'(bmem_write), val_t'(1));
        rst = 1'b1; cla_write = 1'b0; bmem_ready = 1'b0;
        @(negedge clk);
        #1 chk_idle_outputs("mid_wr_rst");
        exp_line = '0; exp_raddr = '0;
        @(negedge clk);
        rst = 1'b0;
        do_read($urandom, rand_line(), 10, -1, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end
endmodule
